// File: rtl/decode_stage_pipelined.sv
// decode_stage_pipelined: register file plus registered ID/EX pipeline boundary.
//   Provides a write-through bypass on reads, load-use hazard detection with
//   bubble insertion, branch flush and back-end hold.
//
// Optional feature macro: STALL_COUNTER_EN
//   Defined   : 16-bit saturating count of stalled cycles drives stall_count.
//   Undefined : stall_count is tied to 0.
//
// Ports:
//   clk, rst (async, active-low)
//   in_valid, opcode, src, dst, ctrl_in : IF/ID instruction and control bundle
//   wb_we, wb_addr, wb_data             : register file write-back port
//   flush, ex_hold                      : branch squash / back-end stall
//   stall_out                           : combinational freeze for PC and IF/ID
//   out_valid, out_opcode, out_src, out_dst,
//   out_rsrc, out_rdst, out_ctrl        : registered ID/EX contents
//   stall_count                         : stall cycle count
module decode_stage_pipelined #(
    parameter int unsigned W           = 16,
    parameter int unsigned N           = 3,
    parameter int unsigned OPW         = 6,
    parameter int unsigned CW          = 14,
    parameter int unsigned MEMREAD_BIT = 13
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [OPW-1:0] opcode,
    input  logic [N-1:0]   src,
    input  logic [N-1:0]   dst,
    input  logic [CW-1:0]  ctrl_in,
    input  logic           wb_we,
    input  logic [N-1:0]   wb_addr,
    input  logic [W-1:0]   wb_data,
    input  logic           flush,
    input  logic           ex_hold,
    output logic           stall_out,
    output logic           out_valid,
    output logic [OPW-1:0] out_opcode,
    output logic [N-1:0]   out_src,
    output logic [N-1:0]   out_dst,
    output logic [W-1:0]   out_rsrc,
    output logic [W-1:0]   out_rdst,
    output logic [CW-1:0]  out_ctrl,
    output logic [15:0]    stall_count
);

    localparam int unsigned NREG = 1 << N;

    logic [W-1:0] regs [NREG];
    logic [W-1:0] rsrc_c;
    logic [W-1:0] rdst_c;
    logic         hazard_c;

    // Register file storage; no hard-wired zero register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_we) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Reads with write-through bypass so a same-cycle write-back is seen.
    always_comb begin
        rsrc_c = regs[src];
        rdst_c = regs[dst];
        if (wb_we && (wb_addr == src)) rsrc_c = wb_data;
        if (wb_we && (wb_addr == dst)) rdst_c = wb_data;
    end

    // Load-use: the load in ID/EX writes a register the incoming instruction reads.
    assign hazard_c = in_valid && out_valid && out_ctrl[MEMREAD_BIT]
                      && ((out_dst == src) || (out_dst == dst));

    assign stall_out = (hazard_c || ex_hold) && !flush;

    // ID/EX boundary: flush > hold > hazard bubble > normal advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_opcode <= '0;
            out_src    <= '0;
            out_dst    <= '0;
            out_rsrc   <= '0;
            out_rdst   <= '0;
            out_ctrl   <= '0;
        end else if (flush || (!ex_hold && hazard_c)) begin
            out_valid  <= 1'b0;
            out_opcode <= '0;
            out_src    <= '0;
            out_dst    <= '0;
            out_rsrc   <= '0;
            out_rdst   <= '0;
            out_ctrl   <= '0;
        end else if (!ex_hold) begin
            out_valid  <= in_valid;
            out_opcode <= opcode;
            out_src    <= src;
            out_dst    <= dst;
            out_rsrc   <= rsrc_c;
            out_rdst   <= rdst_c;
            out_ctrl   <= in_valid ? ctrl_in : '0;
        end
    end

`ifdef STALL_COUNTER_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of cycles in which the front end was frozen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= 16'h0000;
        end else if (stall_out && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = 16'h0000;
`endif

endmodule

// File: doc/decode_stage_pipelined.md
Name: decode_stage_pipelined

Overview:
- Parametrised successor to the single-cycle decode stage: integrated 2^N x W register file plus a registered ID/EX pipeline boundary.
- Adds write-through bypass, load-use hazard detection with bubble insertion, branch flush and back-end hold.
- Sits between fetch (IF/ID) and execute; the control unit stays external and feeds ctrl_in.

Parameters:
- W, 16, datapath / register width
- N, 3, register address bits (2^N registers)
- OPW, 6, opcode width
- CW, 14, control bundle width (MEM+EX+WB signals concatenated)
- MEMREAD_BIT, 13, index of memRead inside the control bundle

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  IF/ID holds a valid instruction
- opcode  in  OPW  instruction opcode
- src  in  N  source register address
- dst  in  N  destination register address
- ctrl_in  in  CW  decoded control bundle from control unit
- wb_we  in  1  write-back enable
- wb_addr  in  N  write-back register address
- wb_data  in  W  write-back data
- flush  in  1  squash instruction entering ID/EX (taken branch)
- ex_hold  in  1  back end stalled; ID/EX must not advance
- stall_out  out  1  freeze PC and IF/ID this cycle
- out_valid  out  1  ID/EX valid
- out_opcode  out  OPW  registered opcode
- out_src  out  N  registered src address
- out_dst  out  N  registered dst address
- out_rsrc  out  W  registered src operand
- out_rdst  out  W  registered dst operand
- out_ctrl  out  CW  registered control bundle
- stall_count  out  16  stall cycle count (see Optional Feature)

Behaviour:
- Reset (rst=0, async): all 2^N registers and all outputs to 0; holds while rst=0.
- Register file write:
  - On the rising edge with wb_we=1, reg[wb_addr] <= wb_data.
  - No hard-wired zero register.
- Register file read:
  - Combinational reads of src and dst.
  - Write-through bypass: if wb_we=1 and wb_addr equals the read address, the read returns wb_data, not the stored value.
- Hazard, combinational: hazard = in_valid & out_valid & out_ctrl[MEMREAD_BIT] & (out_dst==src | out_dst==dst).
- stall_out = (hazard | ex_hold) & ~flush.
- ID/EX update per rising edge, in priority order:
  - 1. flush=1: load a bubble (out_valid=0, out_ctrl=0, other fields 0).
  - 2. ex_hold=1: keep all ID/EX contents unchanged.
  - 3. hazard=1: load a bubble.
  - 4. otherwise: load out_valid=in_valid, opcode, src, dst, bypassed operands, and ctrl_in (or ctrl_in forced to 0 when in_valid=0).
- Latency: one cycle from IF/ID to ID/EX outputs.
- Load-use costs exactly one bubble:
  - The bubble clears out_valid, so the hazard drops on the following cycle.
  - The held instruction then advances.
- Simultaneous wb write and read of the same address: the bypassed value is captured into ID/EX.
- Simultaneous flush and hazard: flush wins; stall_out=0.
- Reset mid-stall: all state clears; stall_out deasserts combinationally because out_valid=0.

Optional Feature:
- Macro: STALL_COUNTER_EN.
- Defined:
  - 16-bit saturating counter increments on each rising edge where stall_out=1.
  - Holds at 16'hFFFF once reached.
  - Cleared by reset.
  - Drives stall_count.
- Undefined: no counter logic; stall_count tied to 0.

Test Plan:
- Reset then read: rst=0 then 1; src=2, dst=5, in_valid=1 -> next cycle out_rsrc=0, out_rdst=0, out_valid=1, out_ctrl=ctrl_in.
- Write then read: wb_we=1, wb_addr=3, wb_data=16'hBEEF, same cycle src=3 -> out_rsrc=16'hBEEF (bypass); a later read of reg 3 also returns 16'hBEEF.
- Load-use:
  - Load with ctrl_in[13]=1, dst=4, then an instruction with src=4.
  - -> stall_out=1 for one cycle; out_valid=0 bubble; next cycle the dependent instruction appears with out_valid=1.
- Flush with hazard pending: flush=1 in the hazard cycle -> stall_out=0, ID/EX bubble, out_ctrl=0.
- ex_hold=1 for 3 cycles -> ID/EX contents unchanged and stall_out=1 throughout; with STALL_COUNTER_EN, stall_count=3.
- Async reset mid-operation: drop rst between edges -> all outputs 0 immediately; register file cleared, so reg 3 then reads 0.
